// File: rtl/fse_adapt_ctrl_if.sv
// Control/status bundle between the adaptive equaliser datapath and its sequencer.
// Slave side is the sequencer: it consumes start/stop/freeze plus slicer errors and drives the strobes.
interface fse_adapt_ctrl_if #(
  parameter int NBT_ERR = 12
);
  logic                      i_start;
  logic                      i_stop;
  logic                      i_freeze;
  logic signed [NBT_ERR-1:0] i_err_I;
  logic signed [NBT_ERR-1:0] i_err_Q;
  logic                      o_en_rx;
  logic                      o_en_rate2;
  logic                      o_en_rate1;
  logic                      o_save_shtrs;
  logic                      o_step_sel;
  logic                      o_locked;
  logic                      o_acq_fail;
  logic [NBT_ERR:0]          o_metric;

  modport master (
    output i_start, i_stop, i_freeze, i_err_I, i_err_Q,
    input  o_en_rx, o_en_rate2, o_en_rate1, o_save_shtrs, o_step_sel, o_locked, o_acq_fail, o_metric
  );

  modport slave (
    input  i_start, i_stop, i_freeze, i_err_I, i_err_Q,
    output o_en_rx, o_en_rate2, o_en_rate1, o_save_shtrs, o_step_sel, o_locked, o_acq_fail, o_metric
  );
endinterface

// File: rtl/fse_adapt_ctrl.sv
// Sequencer for the fractionally-spaced LMS equaliser: strobe generation, flush/acquire/track phases
// and lock detection from windowed slicer-error energy. Every output is a flop.
module fse_adapt_ctrl #(
  parameter int DIV         = 4,
  parameter int NBT_ERR     = 12,
  parameter int NBF_ERR     = 9,
  parameter int LOG2_WIN    = 4,
  parameter int FLUSH_SYM   = 16,
  parameter int ACQ_MAX_WIN = 8,
  parameter int LOCK_THR    = 128,
  parameter int UNLOCK_THR  = 256
) (
  input logic            clk,
  input logic            i_reset,
  fse_adapt_ctrl_if.slave bus
);
  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int SYM_W = $clog2(FLUSH_SYM + 1);
  localparam int ACQ_W = $clog2(ACQ_MAX_WIN + 1);
  localparam int MAG_W = NBT_ERR + 1;
  localparam int ACC_W = NBT_ERR + 1 + LOG2_WIN;

  localparam logic [CNT_W-1:0]    CNT_MAX    = CNT_W'(DIV - 1);
  localparam logic [SYM_W-1:0]    SYM_LAST   = SYM_W'(FLUSH_SYM - 1);
  localparam logic [ACQ_W-1:0]    ACQ_LAST   = ACQ_W'(ACQ_MAX_WIN - 1);
  localparam logic [LOG2_WIN-1:0] WIN_LAST   = '1;
  localparam logic [MAG_W-1:0]    LOCK_LIM   = MAG_W'(LOCK_THR);
  localparam logic [MAG_W-1:0]    UNLOCK_LIM = MAG_W'(UNLOCK_THR);

  if ((DIV < 2) || (NBF_ERR >= NBT_ERR)) begin : g_param_check
    $error("fse_adapt_ctrl: DIV must be >= 2 and NBF_ERR < NBT_ERR");
  end

  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_ACQ, S_TRACK} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                phase_q, phase_d;
  logic [SYM_W-1:0]    sym_q, sym_d;
  logic [LOG2_WIN-1:0] win_q, win_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [ACQ_W-1:0]    acq_win_q, acq_win_d;
  logic                bad_q, bad_d;
  logic                r1_dly_q, r1_dly_d;
  logic [MAG_W-1:0]    metric_q, metric_d;
  logic                en_rx_q, en_rx_d;
  logic                en_rate2_q, en_rate2_d;
  logic                en_rate1_q, en_rate1_d;
  logic                save_shtrs_q, save_shtrs_d;
  logic                step_sel_q, step_sel_d;
  logic                locked_q, locked_d;
  logic                acq_fail_q, acq_fail_d;

  logic [NBT_ERR-1:0]  mag_re, mag_im;
  logic [MAG_W-1:0]    err_sum, win_metric;
  logic [ACC_W-1:0]    acc_sum;
  logic                strobe2, strobe1, sample, win_close;

  // Negating the most negative code yields the same bit pattern, which read unsigned is the exact magnitude.
  assign mag_re  = bus.i_err_I[NBT_ERR-1] ? $unsigned(-bus.i_err_I) : $unsigned(bus.i_err_I);
  assign mag_im  = bus.i_err_Q[NBT_ERR-1] ? $unsigned(-bus.i_err_Q) : $unsigned(bus.i_err_Q);
  assign err_sum = {1'b0, mag_re} + {1'b0, mag_im};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    phase_d    = phase_q;
    sym_d      = sym_q;
    win_d      = win_q;
    acc_d      = acc_q;
    acq_win_d  = acq_win_q;
    bad_d      = bad_q;
    metric_d   = metric_q;
    acq_fail_d = 1'b0;

    strobe2    = (state_q != S_IDLE) && (cnt_q == CNT_MAX);
    strobe1    = strobe2 && phase_q;
    sample     = ((state_q == S_ACQ) || (state_q == S_TRACK)) && !bus.i_freeze && r1_dly_q;
    acc_sum    = acc_q + ACC_W'(err_sum);
    win_close  = sample && (win_q == WIN_LAST);
    win_metric = acc_sum[ACC_W-1:LOG2_WIN];
    r1_dly_d   = strobe1;

    if (state_q != S_IDLE) begin
      cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
      if (strobe2) phase_d = ~phase_q;
    end

    // The closing sample seeds nothing: the next window starts from zero on the following sample.
    if (sample) begin
      win_d = win_q + LOG2_WIN'(1);
      acc_d = win_close ? '0 : acc_sum;
      if (win_close) metric_d = win_metric;
    end

    unique case (state_q)
      S_IDLE: begin
        if (bus.i_start && !bus.i_stop) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if (!bus.i_freeze && strobe1) begin
          if (sym_q == SYM_LAST) begin
            state_d   = S_ACQ;
            win_d     = '0;
            acc_d     = '0;
            acq_win_d = '0;
          end else begin
            sym_d = sym_q + SYM_W'(1);
          end
        end
      end
      S_ACQ: begin
        if (win_close) begin
          if (win_metric < LOCK_LIM) begin
            state_d = S_TRACK;
            bad_d   = 1'b0;
          end else if (acq_win_q == ACQ_LAST) begin
            state_d    = S_FLUSH;
            acq_fail_d = 1'b1;
          end else begin
            acq_win_d = acq_win_q + ACQ_W'(1);
          end
        end
      end
      S_TRACK: begin
        if (win_close) begin
          if (win_metric > UNLOCK_LIM) begin
            if (bad_q) begin
              state_d   = S_ACQ;
              acq_win_d = '0;
              bad_d     = 1'b0;
            end else begin
              bad_d = 1'b1;
            end
          end else begin
            bad_d = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Stop pre-empts any coincident window result, including the metric update and a timeout.
    if (bus.i_stop && (state_q != S_IDLE)) begin
      state_d    = S_IDLE;
      acq_fail_d = 1'b0;
      metric_d   = metric_q;
    end

    if ((state_d == S_IDLE) || ((state_d == S_FLUSH) && (state_q != S_FLUSH))) begin
      cnt_d     = '0;
      phase_d   = 1'b0;
      sym_d     = '0;
      win_d     = '0;
      acc_d     = '0;
      acq_win_d = '0;
      bad_d     = 1'b0;
    end

    en_rx_d      = (state_d != S_IDLE);
    en_rate2_d   = en_rx_d && (cnt_d == CNT_MAX);
    en_rate1_d   = en_rate2_d && phase_d;
    save_shtrs_d = en_rate2_d && !phase_d;
    step_sel_d   = (state_d == S_FLUSH) || (state_d == S_ACQ);
    locked_d     = (state_d == S_TRACK);
  end

  always_ff @(posedge clk) begin
    if (!i_reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      phase_q      <= 1'b0;
      sym_q        <= '0;
      win_q        <= '0;
      acc_q        <= '0;
      acq_win_q    <= '0;
      bad_q        <= 1'b0;
      r1_dly_q     <= 1'b0;
      metric_q     <= '0;
      en_rx_q      <= 1'b0;
      en_rate2_q   <= 1'b0;
      en_rate1_q   <= 1'b0;
      save_shtrs_q <= 1'b0;
      step_sel_q   <= 1'b0;
      locked_q     <= 1'b0;
      acq_fail_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      phase_q      <= phase_d;
      sym_q        <= sym_d;
      win_q        <= win_d;
      acc_q        <= acc_d;
      acq_win_q    <= acq_win_d;
      bad_q        <= bad_d;
      r1_dly_q     <= r1_dly_d;
      metric_q     <= metric_d;
      en_rx_q      <= en_rx_d;
      en_rate2_q   <= en_rate2_d;
      en_rate1_q   <= en_rate1_d;
      save_shtrs_q <= save_shtrs_d;
      step_sel_q   <= step_sel_d;
      locked_q     <= locked_d;
      acq_fail_q   <= acq_fail_d;
    end
  end

  assign bus.o_en_rx      = en_rx_q;
  assign bus.o_en_rate2   = en_rate2_q;
  assign bus.o_en_rate1   = en_rate1_q;
  assign bus.o_save_shtrs = save_shtrs_q;
  assign bus.o_step_sel   = step_sel_q;
  assign bus.o_locked     = locked_q;
  assign bus.o_acq_fail   = acq_fail_q;
  assign bus.o_metric     = metric_q;
endmodule

// File: tb/tb_fse_adapt_ctrl.sv
// Bench for fse_adapt_ctrl: cycle-level behavioural model compared every cycle, directed scenarios
// with literal expectations, then a long randomized run.
module tb_fse_adapt_ctrl;
  localparam int DIV = 4, NBT = 12, LOG2_WIN = 4, WIN = 16, FLUSH_SYM = 16;
  localparam int ACQ_MAX_WIN = 8, LOCK_THR = 128, UNLOCK_THR = 256;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fse_adapt_ctrl_if #(.NBT_ERR(NBT)) bus ();

  fse_adapt_ctrl #(
    .DIV(DIV), .NBT_ERR(NBT), .NBF_ERR(9), .LOG2_WIN(LOG2_WIN), .FLUSH_SYM(FLUSH_SYM),
    .ACQ_MAX_WIN(ACQ_MAX_WIN), .LOCK_THR(LOCK_THR), .UNLOCK_THR(UNLOCK_THR)
  ) dut (
    .clk(clk),
    .i_reset(rst_n),
    .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s at %0t: timed out waiting for DUT event", name, $time);
  endtask

  // Behavioural model. mode: 0 idle, 1 flush, 2 acquisition, 3 tracking.
  // k = cycles since the last flush entry; strobes follow directly from k.
  int m_mode = 0, m_k = 0, m_syms = 0, m_acqw = 0, m_bad = 0, m_metric = 0, m_closes = 0;
  bit m_prev_r1 = 1'b0, m_fail = 1'b0;
  int m_win[$];

  function automatic int mag(input logic signed [NBT-1:0] v);
    int x;
    x = int'(v);
    return (x < 0) ? -x : x;
  endfunction

  always @(posedge clk) begin : model
    int  nmode, s;
    bit  cur_r1, flushin;
    if (!rst_n) begin
      m_mode = 0; m_k = 0; m_syms = 0; m_acqw = 0; m_bad = 0; m_metric = 0;
      m_prev_r1 = 1'b0; m_fail = 1'b0;
      m_win.delete();
    end else begin
      cur_r1  = (m_mode != 0) && (m_k % (2 * DIV) == 2 * DIV - 1);
      nmode   = m_mode;
      flushin = 1'b0;
      m_fail  = 1'b0;
      if (m_mode == 0) begin
        if (bus.i_start && !bus.i_stop) flushin = 1'b1;
      end else if (bus.i_stop) begin
        nmode = 0;
      end else if (m_mode == 1) begin
        if (!bus.i_freeze && cur_r1) begin
          m_syms++;
          if (m_syms == FLUSH_SYM) begin
            nmode = 2;
            m_win.delete();
            m_acqw = 0;
          end
        end
      end else if (!bus.i_freeze && m_prev_r1) begin
        m_win.push_back(mag(bus.i_err_I) + mag(bus.i_err_Q));
        if (m_win.size() == WIN) begin
          s = 0;
          foreach (m_win[i]) s += m_win[i];
          m_win.delete();
          m_metric = s / WIN;
          m_closes++;
          if (m_mode == 2) begin
            if (m_metric < LOCK_THR) begin
              nmode = 3;
              m_bad = 0;
            end else begin
              m_acqw++;
              if (m_acqw == ACQ_MAX_WIN) begin
                m_fail  = 1'b1;
                flushin = 1'b1;
              end
            end
          end else if (m_metric > UNLOCK_THR) begin
            m_bad++;
            if (m_bad == 2) begin
              nmode  = 2;
              m_acqw = 0;
              m_bad  = 0;
            end
          end else begin
            m_bad = 0;
          end
        end
      end
      if (flushin) begin
        nmode = 1; m_k = 0; m_syms = 0; m_acqw = 0; m_bad = 0;
        m_win.delete();
      end else if (nmode == 0) begin
        m_k = 0; m_syms = 0;
        m_win.delete();
      end else begin
        m_k++;
      end
      m_prev_r1 = cur_r1;
      m_mode    = nmode;
    end
  end

  always @(negedge clk) begin : compare
    bit e_en, e_r2, e_r1;
    if (chk_en) begin
      e_en = (m_mode != 0);
      e_r2 = e_en && (m_k % DIV == DIV - 1);
      e_r1 = e_r2 && (m_k % (2 * DIV) == 2 * DIV - 1);
      check("en_rx",      32'(bus.o_en_rx),      32'(e_en));
      check("en_rate2",   32'(bus.o_en_rate2),   32'(e_r2));
      check("en_rate1",   32'(bus.o_en_rate1),   32'(e_r1));
      check("save_shtrs", 32'(bus.o_save_shtrs), 32'(e_r2 && !e_r1));
      check("step_sel",   32'(bus.o_step_sel),   32'(m_mode == 1 || m_mode == 2));
      check("locked",     32'(bus.o_locked),     32'(m_mode == 3));
      check("acq_fail",   32'(bus.o_acq_fail),   32'(m_fail));
      check("metric",     32'(bus.o_metric),     32'(m_metric));
    end
  end

  task automatic wait_close(input string name, input int budget);
    int c0, n;
    c0 = m_closes;
    n  = 0;
    while (m_closes == c0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (m_closes == c0) timeout_fail(name);
  endtask

  task automatic set_err(input int ei, input int eq);
    bus.i_err_I = NBT'(ei);
    bus.i_err_Q = NBT'(eq);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n, amp, v, fz_left;
    bit ok;
    rst_n = 1'b0;
    bus.i_start = 1'b0; bus.i_stop = 1'b0; bus.i_freeze = 1'b0;
    set_err(0, 0);
    @(negedge clk);
    chk_en = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    check("idle_en_rx", 32'(bus.o_en_rx), 0);
    check("idle_metric", 32'(bus.o_metric), 0);

    // Strobe timing from flush entry, then lock at metric 102.
    set_err(51, -51);
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    check("flush_en_rx", 32'(bus.o_en_rx), 1);
    for (int c = 0; c < 16; c++) begin
      check("strobe_rate2", 32'(bus.o_en_rate2), 32'(c % 4 == 3));
      check("strobe_rate1", 32'(bus.o_en_rate1), 32'(c % 8 == 7));
      check("strobe_save", 32'(bus.o_save_shtrs), 32'(c % 8 == 3));
      @(negedge clk);
    end
    wait_close("lock_window", 400);
    check("lock_metric", 32'(bus.o_metric), 102);
    check("lock_locked", 32'(bus.o_locked), 1);
    check("lock_step", 32'(bus.o_step_sel), 0);

    // Unlock hysteresis: one bad window is tolerated, two consecutive drop lock.
    set_err(150, -150);
    wait_close("hyst_w1", 200);
    check("hyst_w1_metric", 32'(bus.o_metric), 300);
    check("hyst_w1_locked", 32'(bus.o_locked), 1);
    set_err(51, 51);
    wait_close("hyst_w2", 200);
    check("hyst_w2_metric", 32'(bus.o_metric), 102);
    check("hyst_w2_locked", 32'(bus.o_locked), 1);
    set_err(150, -150);
    wait_close("hyst_w3", 200);
    check("hyst_w3_locked", 32'(bus.o_locked), 1);
    wait_close("hyst_w4", 200);
    check("unlock_locked", 32'(bus.o_locked), 0);
    check("unlock_step", 32'(bus.o_step_sel), 1);

    // Acquisition timeout after eight windows of metric 400.
    set_err(200, 200);
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 1400) begin
      @(negedge clk);
      n++;
      ok = bus.o_acq_fail;
    end
    if (!ok) timeout_fail("acq_fail_wait");
    check("timeout_metric", 32'(bus.o_metric), 400);
    check("timeout_rate2_k0", 32'(bus.o_en_rate2), 0);
    check("timeout_en_rx", 32'(bus.o_en_rx), 1);
    @(negedge clk);
    check("timeout_pulse_width", 32'(bus.o_acq_fail), 0);
    repeat (2) @(negedge clk);
    check("timeout_rate2_k3", 32'(bus.o_en_rate2), 1);
    check("timeout_save_k3", 32'(bus.o_save_shtrs), 1);

    // Freeze mid-window with a full-scale negative error.
    set_err(-2048, 0);
    n = 0;
    while (m_mode != 2 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (m_mode != 2) timeout_fail("acq_entry_wait");
    repeat (40) @(negedge clk);
    bus.i_freeze = 1'b1;
    repeat (100) @(negedge clk);
    check("freeze_metric", 32'(bus.o_metric), 400);
    check("freeze_step", 32'(bus.o_step_sel), 1);
    bus.i_freeze = 1'b0;
    wait_close("freeze_window", 300);
    check("fullscale_metric", 32'(bus.o_metric), 2048);

    // Stop exactly on the closing sample of the window that would time out.
    set_err(200, 200);
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 2500) begin
      @(negedge clk);
      n++;
      ok = (m_mode == 2) && (m_acqw == ACQ_MAX_WIN - 1) && m_prev_r1 && (m_win.size() == WIN - 1);
    end
    if (!ok) timeout_fail("stop_close_wait");
    bus.i_stop = 1'b1;
    @(negedge clk);
    bus.i_stop = 1'b0;
    check("stop_en_rx", 32'(bus.o_en_rx), 0);
    check("stop_no_fail", 32'(bus.o_acq_fail), 0);
    check("stop_metric_kept", 32'(bus.o_metric), 400);
    check("stop_step", 32'(bus.o_step_sel), 0);

    // Randomized run against the model.
    amp     = 40;
    fz_left = 0;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      if (cyc % 256 == 0) begin
        case ($urandom_range(0, 3))
          0: amp = 40;
          1: amp = 120;
          2: amp = 300;
          default: amp = 2048;
        endcase
      end
      v = int'($urandom_range(0, 2 * amp)) - amp;
      if (v > 2047) v = 2047;
      bus.i_err_I = NBT'(v);
      v = int'($urandom_range(0, 2 * amp)) - amp;
      if (v > 2047) v = 2047;
      bus.i_err_Q = NBT'(v);
      bus.i_start = ($urandom_range(0, 19) == 0);
      bus.i_stop  = ($urandom_range(0, 3999) == 0);
      if (fz_left > 0) begin
        fz_left--;
      end else if ($urandom_range(0, 499) == 0) begin
        fz_left = int'($urandom_range(1, 60));
      end
      bus.i_freeze = (fz_left > 0);
      rst_n = ($urandom_range(0, 7999) != 0);
      @(negedge clk);
    end
    rst_n = 1'b1;
    bus.i_start = 1'b0; bus.i_stop = 1'b0; bus.i_freeze = 1'b0;
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
